// File: rtl/sdram_ctrl_arb.sv
// Two-requester arbiter in front of a single SDRAM core control port, one operation in flight.
// Optional response watchdog is built only when SDRAM_ARB_TIMEOUT_EN is defined.
module sdram_ctrl_arb #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARSTN,

    input  logic                    m0_rd,
    input  logic [DATA_WIDTH/8-1:0] m0_wr,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_write_data,
    output logic                    m0_rdy,
    output logic                    m0_rvalid,
    output logic                    m0_wvalid,
    output logic [DATA_WIDTH-1:0]   m0_read_data,
    output logic                    m0_error,

    input  logic                    m1_rd,
    input  logic [DATA_WIDTH/8-1:0] m1_wr,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_write_data,
    output logic                    m1_rdy,
    output logic                    m1_rvalid,
    output logic                    m1_wvalid,
    output logic [DATA_WIDTH-1:0]   m1_read_data,
    output logic                    m1_error,

    output logic                    s_rd,
    output logic [DATA_WIDTH/8-1:0] s_wr,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_write_data,
    input  logic                    s_rdy,
    input  logic                    s_rvalid,
    input  logic                    s_wvalid,
    input  logic [DATA_WIDTH-1:0]   s_read_data,
    input  logic                    s_error
);

    // state | meaning
    // IDLE  | grant one pending requester (round-robin on ties)
    // ISSUE | present registered command until the core takes it (s_rdy)
    // WAIT  | wait for the matching core response (or watchdog expiry)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int STRB_W = DATA_WIDTH / 8;

    state_t                 state_q, state_d;
    logic                   owner_q;
    logic                   last_q;
    logic                   op_wr_q;
    logic [STRB_W-1:0]      strb_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;

    logic                   pend0, pend1, sel, accept;
    logic                   cmd_fire, rsp_match, rsp_done, tmo_hit;
    logic                   rsp_err;
    logic [DATA_WIDTH-1:0]  rsp_data;

    always_comb begin
        pend0 = m0_rd || (m0_wr != '0);
        pend1 = m1_rd || (m1_wr != '0);
        sel   = pend1;
        if (pend0 && pend1) begin
            sel = ~last_q;
        end
        // Gated with ARSTN so no grant is visible while reset is held.
        accept = ARSTN && (state_q == ST_IDLE) && (pend0 || pend1);
        m0_rdy = accept && !sel;
        m1_rdy = accept && sel;

        cmd_fire = (state_q == ST_ISSUE) && s_rdy;
        s_rd     = cmd_fire && !op_wr_q;
        s_wr     = (cmd_fire && op_wr_q) ? strb_q : '0;

        rsp_match = (state_q == ST_WAIT) && (op_wr_q ? s_wvalid : s_rvalid);
        rsp_done  = rsp_match || tmo_hit;
        rsp_err   = rsp_match ? s_error : 1'b1;
        rsp_data  = (rsp_match && !op_wr_q) ? s_read_data : '0;

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)   state_d = ST_ISSUE;
            ST_ISSUE: if (s_rdy)    state_d = ST_WAIT;
            ST_WAIT:  if (rsp_done) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    assign s_addr       = addr_q;
    assign s_write_data = data_q;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt_q;

    // Loaded as the command leaves ISSUE so that WAIT lasts TIMEOUT_CYCLES cycles.
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            tmo_cnt_q <= '0;
        end else if (cmd_fire) begin
            tmo_cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == ST_WAIT) && (tmo_cnt_q != '0)) begin
            tmo_cnt_q <= tmo_cnt_q - CNT_W'(1);
        end
    end

    assign tmo_hit = (state_q == ST_WAIT) && (tmo_cnt_q == '0);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            op_wr_q <= 1'b0;
            strb_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            if (accept) begin
                owner_q <= sel;
                if (sel) begin
                    op_wr_q <= (m1_wr != '0);
                    strb_q  <= m1_wr;
                    addr_q  <= m1_addr;
                    data_q  <= m1_write_data;
                end else begin
                    op_wr_q <= (m0_wr != '0);
                    strb_q  <= m0_wr;
                    addr_q  <= m0_addr;
                    data_q  <= m0_write_data;
                end
            end
            if (rsp_done) begin
                last_q <= owner_q;
            end
        end
    end

    // Response outputs are single-cycle pulses; everything returns to zero by default.
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            m0_rvalid    <= 1'b0;
            m0_wvalid    <= 1'b0;
            m0_read_data <= '0;
            m0_error     <= 1'b0;
            m1_rvalid    <= 1'b0;
            m1_wvalid    <= 1'b0;
            m1_read_data <= '0;
            m1_error     <= 1'b0;
        end else begin
            m0_rvalid    <= 1'b0;
            m0_wvalid    <= 1'b0;
            m0_read_data <= '0;
            m0_error     <= 1'b0;
            m1_rvalid    <= 1'b0;
            m1_wvalid    <= 1'b0;
            m1_read_data <= '0;
            m1_error     <= 1'b0;
            if (rsp_done) begin
                if (owner_q) begin
                    m1_rvalid    <= !op_wr_q;
                    m1_wvalid    <= op_wr_q;
                    m1_read_data <= rsp_data;
                    m1_error     <= rsp_err;
                end else begin
                    m0_rvalid    <= !op_wr_q;
                    m0_wvalid    <= op_wr_q;
                    m0_read_data <= rsp_data;
                    m0_error     <= rsp_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_ctrl_arb.sv
// Scoreboard bench for sdram_ctrl_arb: expected core commands and requester responses are
// queued as stimulus is driven and popped as the DUT produces them.
module tb_sdram_ctrl_arb;

    logic        ACLK;
    logic        ARSTN;
    logic        m0_rd, m1_rd;
    logic [3:0]  m0_wr, m1_wr;
    logic [31:0] m0_addr, m1_addr, m0_write_data, m1_write_data;
    logic        m0_rdy, m0_rvalid, m0_wvalid, m0_error;
    logic        m1_rdy, m1_rvalid, m1_wvalid, m1_error;
    logic [31:0] m0_read_data, m1_read_data;
    logic        s_rd;
    logic [3:0]  s_wr;
    logic [31:0] s_addr, s_write_data;
    logic        s_rdy, s_rvalid, s_wvalid, s_error;
    logic [31:0] s_read_data;

    sdram_ctrl_arb #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .ACLK          (ACLK),
        .ARSTN         (ARSTN),
        .m0_rd         (m0_rd),
        .m0_wr         (m0_wr),
        .m0_addr       (m0_addr),
        .m0_write_data (m0_write_data),
        .m0_rdy        (m0_rdy),
        .m0_rvalid     (m0_rvalid),
        .m0_wvalid     (m0_wvalid),
        .m0_read_data  (m0_read_data),
        .m0_error      (m0_error),
        .m1_rd         (m1_rd),
        .m1_wr         (m1_wr),
        .m1_addr       (m1_addr),
        .m1_write_data (m1_write_data),
        .m1_rdy        (m1_rdy),
        .m1_rvalid     (m1_rvalid),
        .m1_wvalid     (m1_wvalid),
        .m1_read_data  (m1_read_data),
        .m1_error      (m1_error),
        .s_rd          (s_rd),
        .s_wr          (s_wr),
        .s_addr        (s_addr),
        .s_write_data  (s_write_data),
        .s_rdy         (s_rdy),
        .s_rvalid      (s_rvalid),
        .s_wvalid      (s_wvalid),
        .s_read_data   (s_read_data),
        .s_error       (s_error)
    );

    typedef struct {
        logic        is_wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        logic        owner;
        logic        is_wr;
        logic [31:0] data;
        logic        err;
        logic        tmo;
    } rsp_t;

    cmd_t exp_cmd_q[$];
    rsp_t exp_rsp_q[$];

    int total;
    int bad;
    int cyc;
    int acc_cyc [2];
    int last_cmd_cyc;
    int last_rsp_cyc;

    int          core_lat;
    logic [31:0] core_rdata;
    logic        core_err;
    logic        core_junk;
    logic        core_is_wr;

    logic [3:0]  mon_p;
    logic        mon_prev_rv, mon_prev_wv;
    logic        mon_own, mon_wr, mon_err, mon_lat_ok;
    logic [31:0] mon_data;
    rsp_t        mon_er;
    cmd_t        mon_ec;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic void push_cmd(input logic is_wr, input logic [3:0] strb,
                                     input logic [31:0] addr, input logic [31:0] data);
        cmd_t c;
        c.is_wr = is_wr; c.strb = strb; c.addr = addr; c.data = data;
        exp_cmd_q.push_back(c);
    endfunction

    function automatic void push_rsp(input logic owner, input logic is_wr,
                                     input logic [31:0] data, input logic err, input logic tmo);
        rsp_t r;
        r.owner = owner; r.is_wr = is_wr; r.data = data; r.err = err; r.tmo = tmo;
        exp_rsp_q.push_back(r);
    endfunction

    // Core model: answers each accepted command core_lat cycles later with the right pulse type.
    initial begin
        s_rvalid = 1'b0; s_wvalid = 1'b0; s_read_data = '0; s_error = 1'b0;
        forever begin
            @(negedge ACLK);
            if (ARSTN && (s_rd || s_wr != 4'h0)) begin
                core_is_wr = (s_wr != 4'h0);
                if (core_junk) begin
                    repeat (core_lat - 1) @(posedge ACLK);
                    #1;
                    s_rvalid = core_is_wr; s_wvalid = !core_is_wr;
                    s_read_data = 32'h1234_5678; s_error = 1'b1;
                    @(posedge ACLK);
                    #1;
                end else begin
                    repeat (core_lat) @(posedge ACLK);
                    #1;
                end
                s_rvalid    = !core_is_wr;
                s_wvalid    = core_is_wr;
                s_read_data = core_is_wr ? 32'h0 : core_rdata;
                s_error     = core_err;
                @(posedge ACLK);
                #1;
                s_rvalid = 1'b0; s_wvalid = 1'b0; s_read_data = '0; s_error = 1'b0;
            end
        end
    end

    // Monitor: checks every core command and requester response against the queues.
    initial begin
        mon_prev_rv = 1'b0;
        mon_prev_wv = 1'b0;
        forever begin
            @(negedge ACLK);
            mon_p = {m1_wvalid, m1_rvalid, m0_wvalid, m0_rvalid};
            total++;
            if ((!m0_rvalid && m0_read_data !== 32'h0) || (!m1_rvalid && m1_read_data !== 32'h0) ||
                (!m0_rvalid && !m0_wvalid && m0_error) || (!m1_rvalid && !m1_wvalid && m1_error)) begin
                bad++;
                $display("FAIL quiet_outputs: got rd0=%h err0=%b rd1=%h err1=%b pulses=%b, required 0 without a pulse",
                         m0_read_data, m0_error, m1_read_data, m1_error, mon_p);
            end
            if (mon_p != 4'b0) begin
                total++;
                last_rsp_cyc = cyc;
                if (exp_rsp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: got pulses=%b, required none", mon_p);
                end else begin
                    mon_er     = exp_rsp_q.pop_front();
                    mon_own    = mon_p[3] | mon_p[2];
                    mon_wr     = mon_p[3] | mon_p[1];
                    mon_data   = mon_own ? m1_read_data : m0_read_data;
                    mon_err    = mon_own ? m1_error : m0_error;
                    mon_lat_ok = mon_er.tmo || (mon_er.is_wr ? mon_prev_wv : mon_prev_rv);
                    if ($countones(mon_p) != 1 || mon_own !== mon_er.owner || mon_wr !== mon_er.is_wr ||
                        mon_data !== mon_er.data || mon_err !== mon_er.err || !mon_lat_ok) begin
                        bad++;
                        $display("FAIL rsp: got pulses=%b data=%h err=%b core_prev=%b, required owner=%0d wr=%0d data=%h err=%b",
                                 mon_p, mon_data, mon_err, mon_lat_ok, mon_er.owner, mon_er.is_wr,
                                 mon_er.data, mon_er.err);
                    end
                end
            end
            if (s_rd || s_wr != 4'h0) begin
                total++;
                last_cmd_cyc = cyc;
                if (exp_cmd_q.size() == 0) begin
                    bad++;
                    $display("FAIL cmd_unexpected: got rd=%b wr=%h addr=%h, required none", s_rd, s_wr, s_addr);
                end else begin
                    mon_ec = exp_cmd_q.pop_front();
                    if (s_rd !== !mon_ec.is_wr || s_wr !== (mon_ec.is_wr ? mon_ec.strb : 4'h0) ||
                        s_addr !== mon_ec.addr || (mon_ec.is_wr && s_write_data !== mon_ec.data)) begin
                        bad++;
                        $display("FAIL cmd: got rd=%b wr=%h addr=%h data=%h, required wr_op=%0d strb=%h addr=%h data=%h",
                                 s_rd, s_wr, s_addr, s_write_data, mon_ec.is_wr, mon_ec.strb,
                                 mon_ec.addr, mon_ec.data);
                    end
                end
            end
            mon_prev_rv = s_rvalid;
            mon_prev_wv = s_wvalid;
        end
    end

    // Drives one request and holds it until the DUT grants it; returns at posedge+1.
    task automatic do_req(input logic who, input logic rd, input logic [3:0] wr,
                          input logic [31:0] addr, input logic [31:0] wd);
        int  n;
        bit  got;
        if (who) begin
            m1_rd = rd; m1_wr = wr; m1_addr = addr; m1_write_data = wd;
        end else begin
            m0_rd = rd; m0_wr = wr; m0_addr = addr; m0_write_data = wd;
        end
        got = 1'b0;
        n   = 0;
        while (!got && n < 400) begin
            @(negedge ACLK);
            got = who ? m1_rdy : m0_rdy;
            n++;
        end
        if (got) acc_cyc[who] = cyc;
        @(posedge ACLK);
        #1;
        if (who) begin
            m1_rd = 1'b0; m1_wr = 4'h0; m1_addr = '0; m1_write_data = '0;
        end else begin
            m0_rd = 1'b0; m0_wr = 4'h0; m0_addr = '0; m0_write_data = '0;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL accept_m%0d: got no rdy in %0d cycles, required a grant", who, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0) && n < 300) begin
            @(posedge ACLK);
            n++;
        end
        #1;
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL %s_done: got %0d cmds and %0d rsps outstanding, required 0",
                     name, exp_cmd_q.size(), exp_rsp_q.size());
            exp_cmd_q.delete();
            exp_rsp_q.delete();
        end
    endtask

    task automatic test_reset();
        ARSTN = 1'b0;
        m0_rd = 1'b1; m0_wr = 4'h0; m0_addr = 32'h44; m0_write_data = '0;
        m1_rd = 1'b0; m1_wr = 4'h0; m1_addr = '0;     m1_write_data = '0;
        s_rdy = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        total++;
        if ({m0_rdy, m0_rvalid, m0_wvalid, m0_read_data, m0_error, m1_rdy, m1_rvalid, m1_wvalid,
             m1_read_data, m1_error, s_rd, s_wr, s_addr, s_write_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy0=%b s_rd=%b s_wr=%h s_addr=%h, required all 0",
                     m0_rdy, s_rd, s_wr, s_addr);
        end
        m0_rd = 1'b0; m0_addr = '0;
        #2 ARSTN = 1'b1;
        @(posedge ACLK);
        #1;
        total++;
        if ({m0_rdy, m1_rdy, s_rd, s_wr, s_addr} !== '0) begin
            bad++;
            $display("FAIL reset_release: got rdy0=%b rdy1=%b s_rd=%b s_wr=%h s_addr=%h, required all 0",
                     m0_rdy, m1_rdy, s_rd, s_wr, s_addr);
        end
    endtask

    // Out of reset m0 wins a tie; once m0 was served last, the next tie goes to m1.
    task automatic test_tie();
        core_lat = 2; core_err = 1'b0; core_junk = 1'b0;
        push_cmd(1'b1, 4'hF, 32'h10, 32'hAAAA_5555);
        push_cmd(1'b1, 4'hF, 32'h20, 32'h5555_AAAA);
        push_rsp(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        push_rsp(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        fork
            do_req(1'b0, 1'b0, 4'hF, 32'h10, 32'hAAAA_5555);
            do_req(1'b1, 1'b0, 4'hF, 32'h20, 32'h5555_AAAA);
        join
        wait_idle("tie_first");

        push_cmd(1'b1, 4'hF, 32'h30, 32'h0000_0030);
        push_rsp(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 4'hF, 32'h30, 32'h0000_0030);
        wait_idle("m0_alone");

        push_cmd(1'b1, 4'hF, 32'h50, 32'h0000_0050);
        push_cmd(1'b1, 4'hF, 32'h40, 32'h0000_0040);
        push_rsp(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        push_rsp(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        fork
            do_req(1'b0, 1'b0, 4'hF, 32'h40, 32'h0000_0040);
            do_req(1'b1, 1'b0, 4'hF, 32'h50, 32'h0000_0050);
        join
        wait_idle("tie_second");
    endtask

    task automatic test_read();
        core_lat = 3; core_rdata = 32'hDEAD_BEEF; core_err = 1'b0; core_junk = 1'b0;
        push_cmd(1'b0, 4'h0, 32'h100, 32'h0);
        push_rsp(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 4'h0, 32'h100, 32'h0);
        wait_idle("read");
        total++;
        if (last_rsp_cyc - acc_cyc[0] != 5) begin
            bad++;
            $display("FAIL read_latency: got %0d cycles, required 5", last_rsp_cyc - acc_cyc[0]);
        end
        total++;
        if (s_addr !== 32'h100) begin
            bad++;
            $display("FAIL addr_hold: got %h, required %h", s_addr, 32'h100);
        end

        // Wrong-type pulse first must be ignored; error flag is passed through.
        core_rdata = 32'h0BAD_F00D; core_err = 1'b1; core_junk = 1'b1;
        push_cmd(1'b0, 4'h0, 32'h104, 32'h0);
        push_rsp(1'b1, 1'b0, 32'h0BAD_F00D, 1'b1, 1'b0);
        do_req(1'b1, 1'b1, 4'h0, 32'h104, 32'h0);
        wait_idle("read_junk");
        core_err = 1'b0; core_junk = 1'b0;
    endtask

    task automatic test_stall();
        core_lat = 2;
        s_rdy = 1'b0;
        push_cmd(1'b1, 4'hF, 32'h200, 32'h1122_3344);
        push_rsp(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 4'hF, 32'h200, 32'h1122_3344);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            total++;
            if (s_wr !== 4'h0 || s_rd !== 1'b0) begin
                bad++;
                $display("FAIL stall_cmd_%0d: got s_wr=%h s_rd=%b, required 0", i, s_wr, s_rd);
            end
        end
        @(posedge ACLK);
        #1 s_rdy = 1'b1;
        wait_idle("stall");
    endtask

    task automatic test_rd_wr();
        core_lat = 2;
        push_cmd(1'b1, 4'h3, 32'h300, 32'hCAFE_F00D);
        push_rsp(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 4'h3, 32'h300, 32'hCAFE_F00D);
        wait_idle("rd_wr");
    endtask

    task automatic test_reset_mid();
        core_lat = 8; core_rdata = 32'h5555_0000;
        push_cmd(1'b0, 4'h0, 32'h500, 32'h0);
        do_req(1'b0, 1'b1, 4'h0, 32'h500, 32'h0);
        repeat (3) @(posedge ACLK);
        #1;
        total++;
        if (s_addr !== 32'h500) begin
            bad++;
            $display("FAIL mid_addr: got %h, required %h", s_addr, 32'h500);
        end
        #2 ARSTN = 1'b0;
        #1;
        total++;
        if ({m0_rdy, m0_rvalid, m0_wvalid, m0_read_data, m0_error, m1_rdy, m1_rvalid, m1_wvalid,
             m1_read_data, m1_error, s_rd, s_wr, s_addr, s_write_data} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got s_addr=%h s_rd=%b, required all 0", s_addr, s_rd);
        end
        @(posedge ACLK);
        #3 ARSTN = 1'b1;
        repeat (12) @(posedge ACLK);
        #1;
        wait_idle("reset_mid");

        core_lat = 2; core_rdata = 32'h0000_0600;
        push_cmd(1'b0, 4'h0, 32'h600, 32'h0);
        push_cmd(1'b0, 4'h0, 32'h700, 32'h0);
        push_rsp(1'b0, 1'b0, 32'h0000_0600, 1'b0, 1'b0);
        push_rsp(1'b1, 1'b0, 32'h0000_0600, 1'b0, 1'b0);
        fork
            do_req(1'b0, 1'b1, 4'h0, 32'h600, 32'h0);
            do_req(1'b1, 1'b1, 4'h0, 32'h700, 32'h0);
        join
        wait_idle("tie_after_reset");
    endtask

`ifdef SDRAM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        core_lat = 20; core_rdata = 32'h7777_7777; core_err = 1'b0;
        push_cmd(1'b0, 4'h0, 32'h400, 32'h0);
        push_rsp(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        do_req(1'b0, 1'b1, 4'h0, 32'h400, 32'h0);
        wait_idle("timeout");
        total++;
        if (last_rsp_cyc - last_cmd_cyc != 17) begin
            bad++;
            $display("FAIL timeout_wait: got %0d cycles cmd-to-pulse, required 17",
                     last_rsp_cyc - last_cmd_cyc);
        end
        repeat (12) @(posedge ACLK);
        #1;
        core_lat = 2; core_rdata = 32'h0000_0404;
        push_cmd(1'b0, 4'h0, 32'h404, 32'h0);
        push_rsp(1'b1, 1'b0, 32'h0000_0404, 1'b0, 1'b0);
        do_req(1'b1, 1'b1, 4'h0, 32'h404, 32'h0);
        wait_idle("after_timeout");
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        last_cmd_cyc = 0; last_rsp_cyc = 0;
        core_lat = 2; core_rdata = '0; core_err = 1'b0; core_junk = 1'b0;
        test_reset();
        test_tie();
        test_read();
        test_stall();
        test_rd_wr();
        test_reset_mid();
`ifdef SDRAM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(posedge ACLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
